// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: imem address/data, redirect request and the decode handshake.
// The master side is the fetch queue; the slave side is the imem plus decode environment.
interface if_fetch_queue_if;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_inst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        dec_ready_i;
    logic        dec_valid_o;
    logic [31:0] dec_inst_o;
    logic [31:0] dec_pc_o;
    logic        misalign_o;
    logic        range_err_o;
    logic        halt_o;

    modport master (
        output imem_addr_o, dec_valid_o, dec_inst_o, dec_pc_o,
               misalign_o, range_err_o, halt_o,
        input  imem_inst_i, redirect_i, redirect_pc_i, dec_ready_i
    );

    modport slave (
        input  imem_addr_o, dec_valid_o, dec_inst_o, dec_pc_o,
               misalign_o, range_err_o, halt_o,
        output imem_inst_i, redirect_i, redirect_pc_i, dec_ready_i
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: drives the fetch PC to a combinational imem, queues
// {pc, inst} pairs and hands them to decode; handles redirects and halts on bad PCs.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          IMEM_AW  = 13
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    if_fetch_queue_if.master bus
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] FULL_C  = (PW+1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state_reg;
    logic [31:0]   fpc_reg;
    logic [PW:0]   count_reg;
    logic [PW:0]   count_next;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic          misalign_reg;
    logic          range_err_reg;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic          dec_valid;
    logic          enq;
    logic          deq;
    logic [32:0]   fpc_inc;
    logic          fpc_inc_oor;
    logic          redir_misalign;
    logic          redir_oor;

    assign dec_valid = (count_reg != '0);
    assign deq       = dec_valid && bus.dec_ready_i && !bus.redirect_i;
    // A full queue may still accept a word when the head leaves in the same cycle.
    assign enq       = (state_reg == RUN) && !bus.redirect_i &&
                       ((count_reg != FULL_C) || deq);

    assign fpc_inc        = {1'b0, fpc_reg} + 33'd4;
    assign fpc_inc_oor    = ((fpc_inc >> IMEM_AW) != '0);
    assign redir_misalign = (bus.redirect_pc_i[1:0] != 2'b00);
    assign redir_oor      = ((bus.redirect_pc_i >> IMEM_AW) != '0);

    always_comb begin
        count_next = count_reg;
        if (enq && !deq) begin
            count_next = count_reg + (PW+1)'(1);
        end else if (!enq && deq) begin
            count_next = count_reg - (PW+1)'(1);
        end
    end

    // Queue storage has no reset; only entries below count are ever observed.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i) begin
                if (enq && (wr_ptr_reg == PW'(gi))) begin
                    pc_mem[gi]   <= fpc_reg;
                    inst_mem[gi] <= bus.imem_inst_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= BOOT;
            fpc_reg       <= RESET_PC;
            count_reg     <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            misalign_reg  <= 1'b0;
            range_err_reg <= 1'b0;
        end else if (bus.redirect_i) begin
            // Redirect wins over enqueue and dequeue; the current head is dropped.
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            fpc_reg    <= bus.redirect_pc_i;
            if (redir_misalign || redir_oor) begin
                state_reg     <= HALT;
                misalign_reg  <= misalign_reg | redir_misalign;
                range_err_reg <= range_err_reg | redir_oor;
            end else begin
                state_reg     <= RUN;
                misalign_reg  <= 1'b0;
                range_err_reg <= 1'b0;
            end
        end else begin
            count_reg <= count_next;
            if (state_reg == BOOT) begin
                state_reg <= RUN;
            end
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
                fpc_reg    <= fpc_inc[31:0];
                // The last legal word is already queued; stop before fetching beyond imem.
                if (fpc_inc_oor) begin
                    range_err_reg <= 1'b1;
                    state_reg     <= HALT;
                end
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

    assign bus.imem_addr_o = fpc_reg;
    assign bus.dec_valid_o = dec_valid;
    assign bus.dec_pc_o    = dec_valid ? pc_mem[rd_ptr_reg]   : 32'h0;
    assign bus.dec_inst_o  = dec_valid ? inst_mem[rd_ptr_reg] : NOP;
    assign bus.misalign_o  = misalign_reg;
    assign bus.range_err_o = range_err_reg;
    assign bus.halt_o      = (state_reg == HALT);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a per-cycle vector table plus hand sequences
// for reset-time latency and asynchronous reset mid-stream.
module tb_if_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    if_fetch_queue_if bus ();

    if_fetch_queue #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4),
        .IMEM_AW  (13)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Imem contents: a distinct, address-derived word per location.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign bus.imem_inst_i = imem_word(bus.imem_addr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic        e_mis;
        logic        e_rng;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic redir, input logic [31:0] rpc, input logic rdy,
                       input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_addr,
                       input logic e_mis, input logic e_rng, input logic e_halt);
        vec_t v;
        v.redir = redir;   v.rpc = rpc;     v.rdy = rdy;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_addr = e_addr;
        v.e_mis = e_mis;   v.e_rng = e_rng; v.e_halt = e_halt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " valid"},    32'(bus.dec_valid_o), 32'd0);
        chk({tag, " inst"},     bus.dec_inst_o,       NOP);
        chk({tag, " pc"},       bus.dec_pc_o,         32'h0);
        chk({tag, " addr"},     bus.imem_addr_o,      32'h0);
        chk({tag, " misalign"}, 32'(bus.misalign_o),  32'd0);
        chk({tag, " range"},    32'(bus.range_err_o), 32'd0);
        chk({tag, " halt"},     32'(bus.halt_o),      32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.dec_ready_i   = 1'b1;

        // ---- Reset values, then streaming with decode always ready ----
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        $display("txn reset: outputs checked");
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                chk("t1 boot valid", 32'(bus.dec_valid_o), 32'd0);
            end else begin
                chk($sformatf("t1 c%0d valid", k), 32'(bus.dec_valid_o), 32'd1);
                chk($sformatf("t1 c%0d pc", k), bus.dec_pc_o, 32'((k-2)*4));
                chk($sformatf("t1 c%0d inst", k), bus.dec_inst_o, imem_word(32'((k-2)*4)));
            end
            $display("txn t1 cycle %0d: valid=%0b pc=%h", k, bus.dec_valid_o, bus.dec_pc_o);
        end

        // ---- Async reset mid-stream with entries queued ----
        bus.dec_ready_i = 1'b0;
        @(posedge clk);
        #1;
        chk("t6 pre valid", 32'(bus.dec_valid_o), 32'd1);
        chk("t6 pre pc", bus.dec_pc_o, 32'h18);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6 async");
        $display("txn t6: async reset applied between edges");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.dec_ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("t6 boot valid", 32'(bus.dec_valid_o), 32'd0);
        chk("t6 boot addr", bus.imem_addr_o, 32'h0);
        @(posedge clk);
        #1;
        chk("t6 refetch valid", 32'(bus.dec_valid_o), 32'd1);
        chk("t6 refetch pc", bus.dec_pc_o, 32'h0);
        $display("txn t6: refetch from reset pc pc=%h", bus.dec_pc_o);

        // ---- Vector table, starting from a fresh reset with decode stalled ----
        //   redir rpc           rdy  valid pc            addr          mis rng halt
        add(0, 32'h0,    0, 0, 32'h0,    32'h0,    0, 0, 0); // BOOT
        add(0, 32'h0,    0, 1, 32'h0,    32'h4,    0, 0, 0);
        add(0, 32'h0,    0, 1, 32'h0,    32'h8,    0, 0, 0);
        add(0, 32'h0,    0, 1, 32'h0,    32'hC,    0, 0, 0);
        add(0, 32'h0,    0, 1, 32'h0,    32'h10,   0, 0, 0); // full
        add(0, 32'h0,    0, 1, 32'h0,    32'h10,   0, 0, 0);
        add(0, 32'h0,    0, 1, 32'h0,    32'h10,   0, 0, 0);
        add(0, 32'h0,    0, 1, 32'h0,    32'h10,   0, 0, 0);
        add(0, 32'h0,    1, 1, 32'h4,    32'h14,   0, 0, 0); // full + deq still enqueues
        add(0, 32'h0,    1, 1, 32'h8,    32'h18,   0, 0, 0);
        add(0, 32'h0,    1, 1, 32'hC,    32'h1C,   0, 0, 0);
        add(0, 32'h0,    1, 1, 32'h10,   32'h20,   0, 0, 0);
        add(0, 32'h0,    1, 1, 32'h14,   32'h24,   0, 0, 0);
        add(1, 32'h100,  1, 0, 32'h0,    32'h100,  0, 0, 0); // redirect while full
        add(0, 32'h0,    1, 1, 32'h100,  32'h104,  0, 0, 0);
        add(0, 32'h0,    1, 1, 32'h104,  32'h108,  0, 0, 0);
        add(1, 32'h102,  1, 0, 32'h0,    32'h102,  1, 0, 1); // misaligned
        add(0, 32'h0,    1, 0, 32'h0,    32'h102,  1, 0, 1);
        add(0, 32'h0,    1, 0, 32'h0,    32'h102,  1, 0, 1);
        add(1, 32'h200,  1, 0, 32'h0,    32'h200,  0, 0, 0); // flags clear
        add(0, 32'h0,    1, 1, 32'h200,  32'h204,  0, 0, 0);
        add(1, 32'h1FF8, 1, 0, 32'h0,    32'h1FF8, 0, 0, 0); // end of imem
        add(0, 32'h0,    1, 1, 32'h1FF8, 32'h1FFC, 0, 0, 0);
        add(0, 32'h0,    1, 1, 32'h1FFC, 32'h2000, 0, 1, 1);
        add(0, 32'h0,    1, 0, 32'h0,    32'h2000, 0, 1, 1);
        add(0, 32'h0,    1, 0, 32'h0,    32'h2000, 0, 1, 1);
        add(1, 32'h0,    1, 0, 32'h0,    32'h0,    0, 0, 0); // clears range flag
        add(0, 32'h0,    1, 1, 32'h0,    32'h4,    0, 0, 0);
        add(1, 32'h4000, 1, 0, 32'h0,    32'h4000, 0, 1, 1); // out-of-range target
        add(0, 32'h0,    1, 0, 32'h0,    32'h4000, 0, 1, 1);
        add(1, 32'h40,   0, 0, 32'h0,    32'h40,   0, 0, 0);
        add(0, 32'h0,    0, 1, 32'h40,   32'h44,   0, 0, 0);
        add(0, 32'h0,    0, 1, 32'h40,   32'h48,   0, 0, 0);

        rst_n = 1'b0;
        bus.dec_ready_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            bus.redirect_i    = vecs[i].redir;
            bus.redirect_pc_i = vecs[i].rpc;
            bus.dec_ready_i   = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i), 32'(bus.dec_valid_o), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d pc", i), bus.dec_pc_o, vecs[i].e_pc);
            chk($sformatf("v%0d inst", i), bus.dec_inst_o,
                vecs[i].e_valid ? imem_word(vecs[i].e_pc) : NOP);
            chk($sformatf("v%0d addr", i), bus.imem_addr_o, vecs[i].e_addr);
            chk($sformatf("v%0d misalign", i), 32'(bus.misalign_o), 32'(vecs[i].e_mis));
            chk($sformatf("v%0d range", i), 32'(bus.range_err_o), 32'(vecs[i].e_rng));
            chk($sformatf("v%0d halt", i), 32'(bus.halt_o), 32'(vecs[i].e_halt));
            $display("txn v%0d: redir=%0b rdy=%0b valid=%0b pc=%h addr=%h", i,
                     vecs[i].redir, vecs[i].rdy, bus.dec_valid_o, bus.dec_pc_o, bus.imem_addr_o);
        end
        bus.redirect_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
